pipelined_barrel_shifter: RTL
=============================

// Module: pipelined_barrel_shifter
// PURPOSE
//  Parametrised, pipelined barrel shifter for the ALU datapath. Replaces the
//  fixed-distance shift stages: one log2 stage per pipeline register,
//  selectable SLL/SRL/SRA/ROR, valid/ready handshake with backpressure.
//  Sits between operand select and ALU result mux.
// PARAMETERS
//  WIDTH  32              data width; power of two, >= 4
//  LOG2W  $clog2(WIDTH)   shamt width = pipeline depth (derived; do not override)
// PORTS
//  clock      in   1      single clock, rising edge
//  reset_n    in   1      asynchronous active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      shifter can accept a beat this cycle
//  in_data    in   WIDTH  operand
//  in_shamt   in   LOG2W  shift amount, 0..WIDTH-1
//  in_op      in   2      00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_data   out  WIDTH  shifted result
//  out_zero   out  1      out_data == 0
//  out_ovf    out  1      SLL lost-bit flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits 0; out_valid=0,
//    out_data=0, out_zero=0, out_ovf=0. in_ready=1 from first cycle after reset.
//  - Stage k (k=0..LOG2W-1) shifts by 2^k when shamt[k]=1, else passes.
//    Each stage registers data, op, shamt, sign (in_data[WIDTH-1] captured at
//    entry), ovf accumulator, valid.
//  - Latency: exactly LOG2W cycles from accepted input to out_valid, with no
//    stall. Throughput: 1 beat/cycle.
//  - Fill: SLL/SRL zero-fill; SRA fills with the captured sign; ROR wraps LSBs
//    into MSBs. shamt=0 passes data unchanged for every op.
//  - Handshake: input accepted when in_valid && in_ready. Stall condition is
//    out_valid && !out_ready. On stall, whole pipeline freezes and
//    in_ready=0 (combinational). Bubbles are not collapsed.
//  - While stalled, out_data/out_zero/out_ovf/out_valid held stable.
//  - Out-of-range in_op cannot occur (2-bit, all encodings defined).
//  - Reset mid-operation: all in-flight beats discarded; no partial output.
//  - out_zero registered alongside out_data in final stage (no extra latency).
// CONFIGURATION
//  Macro BARREL_SHIFT_OVF_EN:
//  - Defined: each stage ORs bits shifted out past the MSB (SLL only) into the
//    accumulator. out_ovf=1 iff any nonzero bit left the word. Always 0 for
//    SRL/SRA/ROR.
//  - Undefined: accumulator logic absent; out_ovf tied 0. Port remains.
// TESTING (WIDTH=32, LOG2W=5)
//  1 SRA 0x80000000 shamt 8 -> 0xFF800000 after 5 cycles, zero=0;
//    SRL same -> 0x00800000.
//  2 ROR 0x12345678 shamt 8 -> 0x78123456; ROR shamt 0 -> 0x12345678;
//    SLL 0x000000FF shamt 4 -> 0x00000FF0.
//  3 Back-to-back 8 beats, out_ready=1 -> 8 consecutive out_valid cycles,
//    in order, first at cycle 5.
//  4 out_ready=0 for 3 cycles with full pipe -> in_ready=0, out_data stable,
//    no beat lost or duplicated after release.
//  5 SLL 0xF0000000 shamt 4 -> out_data 0, out_zero=1;
//    out_ovf=1 with BARREL_SHIFT_OVF_EN, 0 without.
//  6 reset_n low with 3 beats in flight -> out_valid=0 immediately,
//    none emerge after release.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined SLL/SRL/SRA/ROR barrel shifter, one log2 stage per register
// Optional feature macro: BARREL_SHIFT_OVF_EN (SLL lost-bit accumulator driving out_ovf).
// Stage k applies a shift of 2^k when shamt[k] is set. Every stage carries its own
// copy of op, shamt, captured sign and valid so beats in flight never interact.
// The whole pipe advances together; a stalled output freezes every stage.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ovf
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Chain index 0 is the input port, index k+1 is the register bank of stage k.
  logic [LOG2W:0][WIDTH-1:0] c_data;
  logic [LOG2W:0][1:0]       c_op;
  logic [LOG2W:0][LOG2W-1:0] c_shamt;
  logic [LOG2W:0]            c_sign;
  logic [LOG2W:0]            c_valid;
`ifdef BARREL_SHIFT_OVF_EN
  logic [LOG2W:0]            c_ovf;
`endif

  logic stall;
  logic unused_tail;

  // A held result at the output freezes the entire pipeline, bubbles included.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // The sign is sampled once at entry so SRA fill never depends on intermediate data.
  assign c_data[0]  = in_data;
  assign c_op[0]    = in_op;
  assign c_shamt[0] = in_shamt;
  assign c_sign[0]  = in_data[WIDTH-1];
  assign c_valid[0] = in_valid;
`ifdef BARREL_SHIFT_OVF_EN
  assign c_ovf[0]   = 1'b0;
`endif

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    localparam int SH = 1 << k;

    logic [WIDTH-1:0] data_d,  data_q;
    logic [1:0]       op_d,    op_q;
    logic [LOG2W-1:0] shamt_d, shamt_q;
    logic             sign_d,  sign_q;
    logic             valid_d, valid_q;

    // Shift by 2^k when this stage's shamt bit is set, otherwise pass through.
    always_comb begin
      data_d  = c_data[k];
      op_d    = c_op[k];
      shamt_d = c_shamt[k];
      sign_d  = c_sign[k];
      valid_d = c_valid[k];
      if (c_shamt[k][k]) begin
        case (c_op[k])
          OP_SLL:  data_d = c_data[k] << SH;
          OP_SRL:  data_d = c_data[k] >> SH;
          OP_SRA:  data_d = {{SH{c_sign[k]}}, c_data[k][WIDTH-1:SH]};
          OP_ROR:  data_d = {c_data[k][SH-1:0], c_data[k][WIDTH-1:SH]};
          default: data_d = c_data[k];
        endcase
      end
    end

    // Stage register bank; holds its contents whenever the output is stalled.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        data_q  <= '0;
        op_q    <= '0;
        shamt_q <= '0;
        sign_q  <= 1'b0;
        valid_q <= 1'b0;
      end else if (!stall) begin
        data_q  <= data_d;
        op_q    <= op_d;
        shamt_q <= shamt_d;
        sign_q  <= sign_d;
        valid_q <= valid_d;
      end
    end

    assign c_data[k+1]  = data_q;
    assign c_op[k+1]    = op_q;
    assign c_shamt[k+1] = shamt_q;
    assign c_sign[k+1]  = sign_q;
    assign c_valid[k+1] = valid_q;

`ifdef BARREL_SHIFT_OVF_EN
    logic ovf_d, ovf_q;

    // Any set bit pushed past the MSB by a left shift marks the result as overflowed.
    always_comb begin
      ovf_d = c_ovf[k];
      if (c_shamt[k][k] && (c_op[k] == OP_SLL)) begin
        ovf_d = c_ovf[k] | (|c_data[k][WIDTH-1 -: SH]);
      end
    end

    // Overflow accumulator travels with its beat.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        ovf_q <= 1'b0;
      end else if (!stall) begin
        ovf_q <= ovf_d;
      end
    end

    assign c_ovf[k+1] = ovf_q;
`endif

    if (k == LOG2W - 1) begin : g_last
      logic zero_d, zero_q;

      // Zero flag computed from the final stage's next data so it adds no latency;
      // gated by valid so an empty pipe reports zero=0.
      always_comb begin
        zero_d = valid_d && (data_d == '0);
      end

      // Zero flag register alongside the final data register.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          zero_q <= 1'b0;
        end else if (!stall) begin
          zero_q <= zero_d;
        end
      end

      assign out_zero = zero_q;
    end
  end

  assign out_valid = c_valid[LOG2W];
  assign out_data  = c_data[LOG2W];

`ifdef BARREL_SHIFT_OVF_EN
  assign out_ovf = c_ovf[LOG2W];
`else
  assign out_ovf = 1'b0;
`endif

  // Control fields of the last stage have no consumer once the result is formed.
  assign unused_tail = ^{c_op[LOG2W], c_shamt[LOG2W], c_sign[LOG2W]};

endmodule
